seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, handshaked successor to the datapath ALU. Combinational ops return a registered
//  result one cycle after accept; MUL/DIV run iteratively over DATA_W cycles, replacing the flat
//  array multiplier/divider. Outputs {HI,LO} plus status flags, and sits between the register
//  read stage and the Z/HI/LO writeback registers.
// PARAMETERS
//  DATA_W   32  operand width; results are 2*DATA_W wide; must be >=8 and a power of two
//  SH_W     5   shift/rotate amount bits, = log2(DATA_W); only in_b[SH_W-1:0] is used
//  OP_W     5   opcode width
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         operation request
//  in_ready   out  1         block can accept; transfer when in_valid & in_ready
//  op_code    in   OP_W      operation; encodings from cpu_pkg (ADD 00011, SUB 00100, AND 00101,
//                            OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011,
//                            ADDI 01100, ANDI 01101, ORI 01110, MUL 01111, DIV 10000, NEG 10001,
//                            NOT 10010, BRANCH 10011, LD/LDI/ST 00000-00010)
//  in_a       in   DATA_W    operand A
//  in_b       in   DATA_W    operand B (immediate already sign-extended)
//  bf         in   1         branch-taken flag, sampled with the request
//  out_valid  out  1         result valid; held until out_ready
//  out_ready  in   1         consumer accepts the result
//  out_hi     out  DATA_W    high word: product[2W-1:W] / remainder / 0
//  out_lo     out  DATA_W    low word: result / product[W-1:0] / quotient
//  flag_z     out  1         out_lo == 0
//  flag_n     out  1         out_lo[DATA_W-1]
//  flag_c     out  1         carry out of ADD/ADDI; borrow-free (no borrow) of SUB; else 0
//  flag_v     out  1         signed overflow of ADD/ADDI/SUB/NEG; else 0
//  flag_dz    out  1         DIV with in_b == 0
//  busy       out  1         iterative op in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_hi, out_lo, every flag and busy = 0; in_ready = 1 once released.
//  FSM: IDLE --accept single-cycle op--> DONE; IDLE --accept MUL/DIV (in_b!=0)--> ITER; ITER --count==DATA_W-1--> DONE;
//   DONE --out_ready--> IDLE, or straight back to DONE/ITER if a new request is accepted in the same cycle.
//  in_ready = (state==IDLE) | (state==DONE & out_ready), giving back-to-back single-cycle ops at 1 op/clk.
//  Latency (accept edge N): single-cycle ops have out_valid at N+1; MUL/DIV have out_valid at N+DATA_W+1.
//  Outputs and flags are stable while out_valid=1 and out_ready=0; a new op is never accepted then.
//  ADD/ADDI/LD/LDI/ST: lo = a+b (mod 2^W). SUB: lo = a-b. NEG: lo = -b. NOT: lo = ~b. AND/OR: bitwise.
//  SHL/SHR are logical; SHRA sign-fills; ROL/ROR rotate by b mod DATA_W. A shift amount of 0 passes a through.
//  BRANCH: lo = bf ? a+b : a. hi = 0 for every non-MUL/DIV op.
//  MUL: two's-complement signed a*b, radix-2 Booth, one step per clock; {hi,lo} = full product.
//  DIV: signed non-restoring division; quotient truncates toward zero, remainder takes the sign of the dividend.
//  DIV by 0: no iteration; out_valid at N+1, lo = all-ones, hi = a, flag_dz = 1.
//  DIV most-negative / -1: lo = most-negative, hi = 0, flag_v = 1 (no trap).
//  Unknown op_code: lo = hi = 0, all flags 0, 1-cycle latency.
//  rst_n low mid-iteration aborts the op; no partial result ever becomes visible.
//  Operands and op are captured at accept; input changes during ITER are ignored.
// STRUCTURE
//  cpu_pkg: opcode localparams, state enum {IDLE,ITER,DONE}, flag bit indices.
//  Sub-module seq_muldiv: Booth/non-restoring engine with start, is_div, a, b inputs and done, hi, lo outputs,
//   its own step counter, and the sign fix-up step. The top level holds the combinational op mux, flags,
//   FSM and output registers.
// TESTING
//  1. ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid at N+1, lo=0x80000000, hi=0, v=1, n=1, c=0.
//  2. MUL -6 * 7 -> out_valid at N+33, {hi,lo} = 0xFFFFFFFF_FFFFFFD6, busy high for 32 cycles.
//  3. DIV -7/2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIV 5/0 -> N+1, lo = 0xFFFFFFFF, hi = 5, dz = 1.
//  4. Back-to-back stream (SHRA 0x80000000 by 4; ROL 0x80000001 by 1) -> 0xF8000000 then 0x00000003,
//     one per clock; with out_ready=0 the result holds and in_ready=0.
//  5. Assert rst_n at cycle 10 of a MUL -> all outputs 0 immediately; the next ADD 2+3 returns lo=5 at N+1.
//  6. BRANCH a=0x100, b=0x20: bf=1 -> 0x120; bf=0 -> 0x100. Unknown op 11111 -> lo=0, flags 0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states and
// flag bit positions.
package seq_alu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_LD     = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI    = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST     = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD    = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND    = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR     = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR    = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHRA   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHL    = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROR    = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ROL    = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ADDI   = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI   = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI    = 5'b01110;
    localparam logic [OPC_W-1:0] OP_MUL    = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV    = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG    = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT    = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BRANCH = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_V  = 3;
    localparam int FLAG_DZ = 4;
    localparam int FLAG_W  = 5;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: radix-2 Booth multiply or non-restoring divide on operand
// magnitudes, one step per clock. The sign fix-up of the divide is folded into
// the final step, so hi_o/lo_o are valid in the same cycle that done_o is high.
module seq_alu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int AW    = DATA_W + 2;

    logic              run_q;
    logic              div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0] qr_q, qr_d;
    logic              q1_q, q1_d;
    logic [DATA_W-1:0] m_q;
    logic              sa_q, sb_q;

    logic [AW-1:0]     m_sx, m_zx, booth_sum, div_shf, div_sum;
    logic [DATA_W-1:0] rem_mag;

    assign done_o = run_q & (cnt_q == CNT_W'(DATA_W - 1));

    // One Booth or non-restoring step computed from the current registers.
    always_comb begin
        m_sx    = {{2{m_q[DATA_W-1]}}, m_q};
        m_zx    = {2'b00, m_q};
        div_shf = {acc_q[AW-2:0], qr_q[DATA_W-1]};
        div_sum = acc_q[AW-1] ? (div_shf + m_zx) : (div_shf - m_zx);
        case ({qr_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_sx;
            2'b10:   booth_sum = acc_q - m_sx;
            default: booth_sum = acc_q;
        endcase
        if (div_q) begin
            acc_d = div_sum;
            qr_d  = {qr_q[DATA_W-2:0], ~div_sum[AW-1]};
            q1_d  = q1_q;
        end else begin
            acc_d = {booth_sum[AW-1], booth_sum[AW-1:1]};
            qr_d  = {booth_sum[0], qr_q[DATA_W-1:1]};
            q1_d  = qr_q[0];
        end
    end

    // Result view of the step above: remainder restore plus sign fix-up for divide.
    always_comb begin
        rem_mag = acc_d[AW-1] ? (acc_d[DATA_W-1:0] + m_q) : acc_d[DATA_W-1:0];
        if (div_q) begin
            lo_o = (sa_q ^ sb_q) ? ('0 - qr_d) : qr_d;
            hi_o = sa_q ? ('0 - rem_mag) : rem_mag;
        end else begin
            hi_o = acc_d[DATA_W-1:0];
            lo_o = qr_d;
        end
    end

    // Operand load on start, then step until the final count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            qr_q  <= '0;
            q1_q  <= 1'b0;
            m_q   <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
        end else if (start_i) begin
            run_q <= 1'b1;
            div_q <= is_div_i;
            cnt_q <= '0;
            acc_q <= '0;
            q1_q  <= 1'b0;
            sa_q  <= a_i[DATA_W-1];
            sb_q  <= b_i[DATA_W-1];
            if (is_div_i) begin
                qr_q <= a_i[DATA_W-1] ? ('0 - a_i) : a_i;
                m_q  <= b_i[DATA_W-1] ? ('0 - b_i) : b_i;
            end else begin
                qr_q <= a_i;
                m_q  <= b_i;
            end
        end else if (run_q) begin
            acc_q <= acc_d;
            qr_q  <= qr_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops are registered at accept, MUL/DIV are handed
// to the iterative engine and their result is registered when it finishes.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [OP_W-1:0]   op_code_i,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic              bf_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_hi_o,
    output logic [DATA_W-1:0] out_lo_o,
    output logic              flag_z_o,
    output logic              flag_n_o,
    output logic              flag_c_o,
    output logic              flag_v_o,
    output logic              flag_dz_o,
    output logic              busy_o
);

    localparam int M = DATA_W - 1;

    state_e            state_q, state_d;
    logic              accept, iter_req, div_ovf;
    logic              eng_done;
    logic [DATA_W-1:0] eng_hi, eng_lo;

    logic [DATA_W:0]   sum_w, dif_w;
    logic [DATA_W-1:0] neg_b, rot_v;
    logic [SH_W-1:0]   sh, rot_amt;
    logic [DATA_W-1:0] res_hi, res_lo;
    logic [FLAG_W-1:0] res_fl;
    logic              known;

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [FLAG_W-1:0] fl_q;
    logic              ovf_q;

    assign accept   = in_valid_i & in_ready_o;
    assign iter_req = (op_code_i == OP_MUL) | ((op_code_i == OP_DIV) & (in_b_i != '0));
    assign div_ovf  = (in_a_i == {1'b1, {M{1'b0}}}) & (in_b_i == '1);

    assign sum_w   = {1'b0, in_a_i} + {1'b0, in_b_i};
    assign dif_w   = {1'b0, in_a_i} - {1'b0, in_b_i};
    assign neg_b   = '0 - in_b_i;
    assign sh      = in_b_i[SH_W-1:0];
    // A left rotate is a right rotate by the complementary amount.
    assign rot_amt = (op_code_i == OP_ROL) ? ('0 - sh) : sh;
    assign rot_v   = DATA_W'({in_a_i, in_a_i} >> rot_amt);

    seq_alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept & iter_req),
        .is_div_i (op_code_i == OP_DIV),
        .a_i      (in_a_i),
        .b_i      (in_b_i),
        .done_o   (eng_done),
        .hi_o     (eng_hi),
        .lo_o     (eng_lo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE can chain straight into a new op when the result is taken.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = iter_req ? ITER : DONE;
        end else begin
            case (state_q)
                ITER:    if (eng_done) state_d = DONE;
                DONE:    if (out_ready_i) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q == ITER);
    end

    // Single-cycle result mux and its flags.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_fl = '0;
        known  = 1'b1;
        case (op_code_i)
            OP_LD, OP_LDI, OP_ST: res_lo = sum_w[M:0];
            OP_ADD, OP_ADDI: begin
                res_lo         = sum_w[M:0];
                res_fl[FLAG_C] = sum_w[DATA_W];
                res_fl[FLAG_V] = (in_a_i[M] == in_b_i[M]) & (sum_w[M] != in_a_i[M]);
            end
            OP_SUB: begin
                res_lo         = dif_w[M:0];
                res_fl[FLAG_C] = ~dif_w[DATA_W];
                res_fl[FLAG_V] = (in_a_i[M] != in_b_i[M]) & (dif_w[M] != in_a_i[M]);
            end
            OP_NEG: begin
                res_lo         = neg_b;
                res_fl[FLAG_V] = in_b_i[M] & neg_b[M];
            end
            OP_NOT:          res_lo = ~in_b_i;
            OP_AND, OP_ANDI: res_lo = in_a_i & in_b_i;
            OP_OR, OP_ORI:   res_lo = in_a_i | in_b_i;
            OP_SHR:          res_lo = in_a_i >> sh;
            OP_SHRA:         res_lo = $unsigned($signed(in_a_i) >>> sh);
            OP_SHL:          res_lo = in_a_i << sh;
            OP_ROR, OP_ROL:  res_lo = rot_v;
            OP_BRANCH:       res_lo = bf_i ? sum_w[M:0] : in_a_i;
            OP_DIV: begin
                // Only the divide-by-zero case takes this single-cycle path.
                res_lo          = '1;
                res_hi          = in_a_i;
                res_fl[FLAG_DZ] = 1'b1;
            end
            OP_MUL:          res_lo = '0;
            default:         known  = 1'b0;
        endcase
        if (known) begin
            res_fl[FLAG_Z] = (res_lo == '0);
            res_fl[FLAG_N] = res_lo[M];
        end
    end

    // Output registers: load at single-cycle accept or when the engine finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            fl_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (accept & iter_req) ovf_q <= (op_code_i == OP_DIV) & div_ovf;
            if (accept & ~iter_req) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                fl_q <= res_fl;
            end else if ((state_q == ITER) & eng_done) begin
                hi_q           <= eng_hi;
                lo_q           <= eng_lo;
                fl_q           <= '0;
                fl_q[FLAG_Z]   <= (eng_lo == '0);
                fl_q[FLAG_N]   <= eng_lo[M];
                fl_q[FLAG_V]   <= ovf_q;
            end
        end
    end

    assign out_hi_o  = hi_q;
    assign out_lo_o  = lo_q;
    assign flag_z_o  = fl_q[FLAG_Z];
    assign flag_n_o  = fl_q[FLAG_N];
    assign flag_c_o  = fl_q[FLAG_C];
    assign flag_v_o  = fl_q[FLAG_V];
    assign flag_dz_o = fl_q[FLAG_DZ];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors plus randomized ops checked
// against an arithmetic reference model.
module tb_seq_alu;

    localparam logic [4:0] T_ADD = 5'd3,  T_SUB = 5'd4,  T_SHRA = 5'd8, T_SHL = 5'd9;
    localparam logic [4:0] T_ROL = 5'd11, T_MUL = 5'd15, T_DIV = 5'd16, T_BR = 5'd19;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        bf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_hi, out_lo;
    logic        fz, fn, fc, fv, fdz, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  fl;   // {dz, v, c, n, z}
        int          due;  // latency on push, absolute cycle once queued
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    bit   presented = 1'b0;

    seq_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_code_i   (op),
        .in_a_i      (a),
        .in_b_i      (b),
        .bf_i        (bf),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_hi_o    (out_hi),
        .out_lo_o    (out_lo),
        .flag_z_o    (fz),
        .flag_n_o    (fn),
        .flag_c_o    (fc),
        .flag_v_o    (fv),
        .flag_dz_o   (fdz),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t lit(input logic [31:0] hi, input logic [31:0] lo,
                                 input logic [4:0] fl, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.fl = fl; e.due = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] ia,
                                   input logic [31:0] ib, input logic ibf);
        exp_t        e;
        longint      sa, sbv, r, q, rm;
        logic [32:0] u;
        logic [31:0] x;
        logic        c, v, dz, known;
        sa = longint'($signed(ia));
        sbv = longint'($signed(ib));
        e.hi = '0; e.lo = '0; e.due = 0;
        c = 1'b0; v = 1'b0; dz = 1'b0; known = 1'b1;
        case (o)
            5'd0, 5'd1, 5'd2: e.lo = ia + ib;
            5'd3, 5'd12: begin
                u = {1'b0, ia} + {1'b0, ib};
                e.lo = u[31:0]; c = u[32];
                r = sa + sbv; v = (r > MAXP) || (r < MINN);
            end
            5'd4: begin
                e.lo = ia - ib; c = (ia >= ib);
                r = sa - sbv; v = (r > MAXP) || (r < MINN);
            end
            5'd5, 5'd13: e.lo = ia & ib;
            5'd6, 5'd14: e.lo = ia | ib;
            5'd7:  e.lo = ia >> ib[4:0];
            5'd8:  e.lo = $unsigned($signed(ia) >>> ib[4:0]);
            5'd9:  e.lo = ia << ib[4:0];
            5'd10: begin
                x = ia;
                for (int i = 0; i < int'(ib[4:0]); i++) x = {x[0], x[31:1]};
                e.lo = x;
            end
            5'd11: begin
                x = ia;
                for (int i = 0; i < int'(ib[4:0]); i++) x = {x[30:0], x[31]};
                e.lo = x;
            end
            5'd15: begin
                r = sa * sbv;
                e.hi = r[63:32]; e.lo = r[31:0]; e.due = 32;
            end
            5'd16: begin
                if (ib == 32'd0) begin
                    e.lo = '1; e.hi = ia; dz = 1'b1;
                end else begin
                    q = sa / sbv; rm = sa % sbv;
                    e.lo = q[31:0]; e.hi = rm[31:0]; v = (q > MAXP); e.due = 32;
                end
            end
            5'd17: begin
                r = -sbv; e.lo = r[31:0]; v = (r > MAXP);
            end
            5'd18: e.lo = ~ib;
            5'd19: e.lo = ibf ? ia + ib : ia;
            default: known = 1'b0;
        endcase
        e.fl = {dz, v, c, known && (e.lo[31] == 1'b1), known && (e.lo == 32'd0)};
        return e;
    endfunction

    // Monitor: compare each result when it first appears, then require it to hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("ready_while_busy", {63'd0, in_ready}, 64'd0);
            if (out_valid) begin
                if (!presented) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_result: lo=%h with empty scoreboard", out_lo);
                    end else begin
                        held = sb_q[0];
                        presented = 1'b1;
                        chk("latency", 64'(cyc), 64'(held.due));
                        chk("hi", {32'd0, out_hi}, {32'd0, held.hi});
                        chk("lo", {32'd0, out_lo}, {32'd0, held.lo});
                        chk("flags", {59'd0, fdz, fv, fc, fn, fz}, {59'd0, held.fl});
                    end
                end else begin
                    chk("hold_lo", {32'd0, out_lo}, {32'd0, held.lo});
                    chk("hold_hi", {32'd0, out_hi}, {32'd0, held.hi});
                    chk("hold_flags", {59'd0, fdz, fv, fc, fn, fz}, {59'd0, held.fl});
                end
                if (!out_ready) begin
                    chk("ready_while_held", {63'd0, in_ready}, 64'd0);
                end else begin
                    if (presented) void'(sb_q.pop_front());
                    presented = 1'b0;
                end
            end
        end
    end

    // Consumer: out_ready always high, random, or forced low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Issue one request (called at posedge+1); returns the accept cycle.
    task automatic send(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ibf, input exp_t e, output int acc_cyc);
        op = o; a = ia; b = ib; bf = ibf; in_valid = 1'b1;
        acc_cyc = -1;
        for (int t = 0; t < 200 && acc_cyc < 0; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc + 1;
                e.due = acc_cyc + e.due;
                sb_q.push_back(e);
            end
        end
        if (acc_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: op %b not accepted in 200 cycles", o);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            ok = (sb_q.size() == 0) && !out_valid;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ac1, ac2, bc;
        bit seen;
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        logic        rbf;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hi", {32'd0, out_hi}, 64'd0);
        chk("rst_lo", {32'd0, out_lo}, 64'd0);
        chk("rst_flags", {59'd0, fdz, fv, fc, fn, fz}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // ADD overflow
        send(T_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, lit(32'h0, 32'h8000_0000, 5'b01010, 0), ac1);
        drain();

        // MUL -6*7 with busy duration
        send(T_MUL, 32'hFFFF_FFFA, 32'd7, 1'b0, lit(32'hFFFF_FFFF, 32'hFFFF_FFD6, 5'b00010, 32), ac1);
        bc = 0; seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (busy) bc++;
        end
        chk("mul_busy_cycles", 64'(bc), 64'd32);
        drain();

        // DIV signed, by zero, most-negative by -1
        send(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 5'b00010, 32), ac1);
        send(T_DIV, 32'd5, 32'd0, 1'b0, lit(32'd5, 32'hFFFF_FFFF, 5'b10010, 0), ac1);
        send(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lit(32'd0, 32'h8000_0000, 5'b01010, 32), ac1);
        drain();

        // Back-to-back stream, then a held result
        send(T_SHRA, 32'h8000_0000, 32'd4, 1'b0, lit(32'd0, 32'hF800_0000, 5'b00010, 0), ac1);
        send(T_ROL, 32'h8000_0001, 32'd1, 1'b0, lit(32'd0, 32'h0000_0003, 5'b00000, 0), ac2);
        chk("b2b_accept", 64'(ac2), 64'(ac1 + 1));
        rdy_mode = 2;
        send(T_SHL, 32'd1, 32'd3, 1'b0, lit(32'd0, 32'd8, 5'b00000, 0), ac1);
        op = T_SUB; a = 32'd9; b = 32'd4; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of a MUL
        send(T_MUL, 32'hFFFF_FFFA, 32'd7, 1'b0, lit(32'hFFFF_FFFF, 32'hFFFF_FFD6, 5'b00010, 32), ac1);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_hi", {32'd0, out_hi}, 64'd0);
        chk("abort_lo", {32'd0, out_lo}, 64'd0);
        chk("abort_flags", {59'd0, fdz, fv, fc, fn, fz}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        sb_q.delete();
        presented = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(T_ADD, 32'd2, 32'd3, 1'b0, lit(32'd0, 32'd5, 5'b00000, 0), ac1);
        drain();

        // BRANCH and unknown opcode
        send(T_BR, 32'h100, 32'h20, 1'b1, lit(32'd0, 32'h120, 5'b00000, 0), ac1);
        send(T_BR, 32'h100, 32'h20, 1'b0, lit(32'd0, 32'h100, 5'b00000, 0), ac1);
        send(5'b11111, 32'h1234, 32'h5678, 1'b0, lit(32'd0, 32'd0, 5'b00000, 0), ac1);
        drain();

        // Randomized ops against the model with a random consumer
        rdy_mode = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) ro = ($urandom_range(0, 1) != 0) ? T_MUL : T_DIV;
            else ro = 5'($urandom_range(0, 31));
            ra  = rand_val();
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : rand_val();
            rbf = 1'($urandom_range(0, 1));
            send(ro, ra, rb, rbf, model(ro, ra, rb, rbf), ac1);
        end
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
